// File: rtl/timer_periph_pkg.sv
// Shared constants and helpers for the memory-mapped timer.
// Register offsets, CTRL bit indices, window base and a byte-merge helper.
package timer_periph_pkg;

    localparam logic [19:0] TMR_BASE     = 20'h80001;

    localparam logic [11:0] TMR_CTRL     = 12'h000;
    localparam logic [11:0] TMR_PRESCALE = 12'h004;
    localparam logic [11:0] TMR_COUNT    = 12'h008;
    localparam logic [11:0] TMR_COMPARE  = 12'h00C;
    localparam logic [11:0] TMR_STATUS   = 12'h010;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    function automatic logic [31:0] be_merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_periph_if.sv
// Data-bus slave interface for the timer window.
// master drives select/we/addr/wdata/be; slave returns combinational rdata.
interface timer_periph_if;

    logic        cs_timer_n;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;

    modport master (
        output cs_timer_n, we, addr, wdata, be,
        input  rdata
    );

    modport slave (
        input  cs_timer_n, we, addr, wdata, be,
        output rdata
    );

endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..prescale while en, emitting a one-cycle tick on wrap.
// Ports: clk, reset_n, en, prescale, clr (restart period), tick.
module timer_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] prescale,
    input  logic         clr,
    output logic         tick
);

    logic [W-1:0] pcnt;

    assign tick = en && (pcnt == prescale);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt <= '0;
        end else if (!en || clr || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + W'(1);
        end
    end

endmodule

// File: rtl/timer_periph.sv
// 32-bit memory-mapped timer: CTRL/PRESCALE/COUNT/COMPARE/STATUS registers.
// Ports: clk, reset_n, bus (slave), timer_irq (registered level interrupt).
module timer_periph
    import timer_periph_pkg::*;
#(
    parameter int          PRESCALE_W = 16,
    parameter logic [31:0] CNT_RESET  = 32'h0
) (
    input  logic           clk,
    input  logic           reset_n,
    timer_periph_if.slave  bus,
    output logic           timer_irq
);

    logic [2:0]            ctrl_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] prescale_nxt;
    logic [31:0]           count_q;
    logic [31:0]           count_nxt;
    logic [31:0]           compare_q;
    logic                  match_q;
    logic                  match_set;
    logic                  irq_q;
    logic                  tick;
    logic                  tick_ok;

    logic        acc;
    logic        wr;
    logic        rd;
    logic [11:0] off;
    logic        sel_ctrl;
    logic        sel_pre;
    logic        sel_cnt;
    logic        sel_cmp;
    logic        sel_stat;

    // Low address bits are masked out so that word offsets decode alike.
    assign off      = bus.addr & 12'hFFC;
    assign acc      = !bus.cs_timer_n;
    assign wr       = acc && bus.we;
    assign rd       = acc && !bus.we;
    assign sel_ctrl = (off == TMR_CTRL);
    assign sel_pre  = (off == TMR_PRESCALE);
    assign sel_cnt  = (off == TMR_COUNT);
    assign sel_cmp  = (off == TMR_COMPARE);
    assign sel_stat = (off == TMR_STATUS);

    timer_prescaler #(
        .W (PRESCALE_W)
    ) u_pre (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (ctrl_q[CTRL_EN]),
        .prescale (prescale_q),
        .clr      (wr && sel_pre),
        .tick     (tick)
    );

    // A CTRL write that drops EN kills the tick of the same cycle.
    assign tick_ok = tick &&
        !(wr && sel_ctrl && bus.be[0] && !bus.wdata[CTRL_EN]);

    always_comb begin
        prescale_nxt = prescale_q;
        for (int i = 0; i < PRESCALE_W; i++) begin
            if (bus.be[i/8]) prescale_nxt[i] = bus.wdata[i];
        end
    end

    always_comb begin
        count_nxt = count_q;
        match_set = 1'b0;
        if (tick_ok) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                count_nxt = ctrl_q[CTRL_AR] ? 32'h0 : count_q + 32'h1;
            end else begin
                count_nxt = count_q + 32'h1;
            end
        end
        // Software write wins over the tick update.
        if (wr && sel_cnt) begin
            count_nxt = be_merge(count_q, bus.wdata, bus.be);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= CNT_RESET;
            compare_q  <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (wr && sel_ctrl && bus.be[0]) begin
                ctrl_q <= bus.wdata[2:0];
            end
            if (wr && sel_pre) begin
                prescale_q <= prescale_nxt;
            end
            if (wr && sel_cmp) begin
                compare_q <= be_merge(compare_q, bus.wdata, bus.be);
            end
            count_q <= count_nxt;
            // A new match holds the flag even against a clear.
            if (match_set) begin
                match_q <= 1'b1;
            end else if (wr && sel_stat && bus.be[0] && bus.wdata[0]) begin
                match_q <= 1'b0;
            end
            irq_q <= match_q && ctrl_q[CTRL_IE];
        end
    end

    assign timer_irq = irq_q;

    always_comb begin
        bus.rdata = '0;
        if (rd) begin
            unique case (1'b1)
                sel_ctrl: bus.rdata = {29'b0, ctrl_q};
                sel_pre:  bus.rdata = 32'(prescale_q);
                sel_cnt:  bus.rdata = count_q;
                sel_cmp:  bus.rdata = compare_q;
                sel_stat: bus.rdata = {31'b0, match_q};
                default:  bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_periph.sv
// Directed bench for timer_periph with a scoreboard of expected read values.
// Drives the bus interface, checks reads and timer_irq.
module tb_timer_periph;
    import timer_periph_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic irq;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_q[$];

    timer_periph_if bus();

    timer_periph #(
        .PRESCALE_W (16),
        .CNT_RESET  (32'h0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .timer_irq (irq)
    );

    always #10 clk = ~clk;

    function automatic int ticks(input int edges, input int p);
        return edges / (p + 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] b = 4'hF);
        @(negedge clk);
        bus.cs_timer_n = 1'b0;
        bus.we = 1'b1;
        bus.addr = a;
        bus.wdata = d;
        bus.be = b;
        @(posedge clk);
        #1;
        bus.cs_timer_n = 1'b1;
        bus.we = 1'b0;
        bus.be = 4'h0;
    endtask

    task automatic wr_nocs(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs_timer_n = 1'b1;
        bus.we = 1'b1;
        bus.addr = a;
        bus.wdata = d;
        bus.be = 4'hF;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        bus.be = 4'h0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e,
                      input string tag);
        logic [31:0] got;
        exp_q.push_back(e);
        bus.cs_timer_n = 1'b0;
        bus.we = 1'b0;
        bus.addr = a;
        #1;
        got = bus.rdata;
        bus.cs_timer_n = 1'b1;
        check(tag, got, exp_q.pop_front());
    endtask

    task automatic rd_nocs(input logic [11:0] a, input string tag);
        logic [31:0] got;
        exp_q.push_back(32'h0);
        bus.cs_timer_n = 1'b1;
        bus.we = 1'b0;
        bus.addr = a;
        #1;
        got = bus.rdata;
        check(tag, got, exp_q.pop_front());
    endtask

    task automatic chk_irq(input logic e, input string tag);
        exp_q.push_back({31'b0, e});
        check(tag, {31'b0, irq}, exp_q.pop_front());
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cs_timer_n = 1'b1;
        bus.we = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        bus.be = '0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // reset in the middle of counting
        wr(TMR_COUNT, 32'h55);
        wr(TMR_CTRL, 32'h1);
        cyc(3);
        rd(TMR_COUNT, 32'h58, "precount");
        #1 reset_n = 1'b0;
        rd(TMR_COUNT, 32'h0, "rst_count");
        rd(TMR_CTRL, 32'h0, "rst_ctrl");
        rd(TMR_STATUS, 32'h0, "rst_status");
        rd(TMR_COMPARE, 32'hFFFF_FFFF, "rst_compare");
        rd(TMR_PRESCALE, 32'h0, "rst_prescale");
        chk_irq(1'b0, "rst_irq");
        @(negedge clk);
        reset_n = 1'b1;

        // basic count, tick every cycle
        wr(TMR_PRESCALE, 32'h0);
        wr(TMR_COUNT, 32'h0);
        wr(TMR_CTRL, 32'h1);
        cyc(10);
        rd(TMR_COUNT, 32'(ticks(10, 0)), "basic_count");
        chk_irq(1'b0, "basic_irq");
        wr(TMR_CTRL, 32'h0);

        // prescaler 3 and mid-period restart
        wr(TMR_COUNT, 32'h0);
        wr(TMR_PRESCALE, 32'h3);
        wr(TMR_CTRL, 32'h1);
        cyc(16);
        rd(TMR_COUNT, 32'(ticks(16, 3)), "pre_count");
        cyc(2);
        wr(TMR_PRESCALE, 32'h3);
        cyc(3);
        rd(TMR_COUNT, 32'h4, "pre_restart_hold");
        cyc(1);
        rd(TMR_COUNT, 32'h5, "pre_restart_tick");
        wr(TMR_CTRL, 32'h0);
        wr(TMR_PRESCALE, 32'h0);

        // match with auto-reload and irq
        wr(TMR_COUNT, 32'h0);
        wr(TMR_COMPARE, 32'h5);
        wr(TMR_CTRL, 32'h7);
        cyc(5);
        rd(TMR_COUNT, 32'h5, "ar_count5");
        rd(TMR_STATUS, 32'h0, "ar_nomatch");
        cyc(1);
        rd(TMR_COUNT, 32'h0, "ar_reload");
        rd(TMR_STATUS, 32'h1, "ar_match");
        chk_irq(1'b0, "ar_irq_late");
        cyc(1);
        chk_irq(1'b1, "ar_irq");
        rd(TMR_COUNT, 32'h1, "ar_count1");
        wr(TMR_STATUS, 32'h1);
        cyc(1);
        chk_irq(1'b0, "ar_irq_clr");
        rd(TMR_STATUS, 32'h0, "ar_status_clr");
        wr(TMR_CTRL, 32'h0);

        // match without auto-reload
        wr(TMR_COUNT, 32'h0);
        wr(TMR_CTRL, 32'h5);
        cyc(6);
        rd(TMR_COUNT, 32'h6, "noar_count");
        rd(TMR_STATUS, 32'h1, "noar_match");
        cyc(1);
        chk_irq(1'b1, "noar_irq");
        wr(TMR_CTRL, 32'h0);

        // status clear colliding with a new match
        wr(TMR_STATUS, 32'h1);
        rd(TMR_STATUS, 32'h0, "coll_pre_clr");
        wr(TMR_COUNT, 32'h3);
        wr(TMR_CTRL, 32'h1);
        cyc(2);
        wr(TMR_STATUS, 32'h1);
        rd(TMR_STATUS, 32'h1, "coll_match_wins");
        rd(TMR_COUNT, 32'h6, "coll_count");

        // count write on a tick cycle, then EN clear kills the tick
        wr(TMR_COUNT, 32'h100);
        rd(TMR_COUNT, 32'h100, "cnt_write_wins");
        wr(TMR_CTRL, 32'h0);
        rd(TMR_COUNT, 32'h100, "en_clr_no_tick");

        // byte-enable write
        wr(TMR_COUNT, 32'h1234_5600);
        wr(TMR_COUNT, 32'hFFFF_FFAB, 4'b0001);
        rd(TMR_COUNT, 32'h1234_56AB, "be_write");

        // decode isolation
        wr_nocs(TMR_COUNT, 32'hDEAD_BEEF);
        rd_nocs(TMR_COUNT, "nocs_rdata");
        rd(TMR_COUNT, 32'h1234_56AB, "nocs_nowrite");

        // register widths
        wr(TMR_PRESCALE, 32'h0001_2345);
        rd(TMR_PRESCALE, 32'h0000_2345, "prescale_width");
        wr(TMR_PRESCALE, 32'h0);
        wr(TMR_CTRL, 32'hFFFF_FFFE);
        rd(TMR_CTRL, 32'h6, "ctrl_bits");
        wr(TMR_CTRL, 32'h0);

        // wrap without match
        wr(TMR_COMPARE, 32'h0);
        wr(TMR_COUNT, 32'hFFFF_FFFF);
        wr(TMR_STATUS, 32'h1);
        wr(TMR_CTRL, 32'h1);
        cyc(1);
        rd(TMR_COUNT, 32'h0, "wrap_count");
        rd(TMR_STATUS, 32'h0, "wrap_nomatch");
        wr(TMR_CTRL, 32'h0);
        rd(TMR_STATUS, 32'h0, "wrap_stop");

        // unmapped offset
        rd(12'h020, 32'h0, "unmapped");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
